game_fsm_ctl: RTL

GAME_FSM_CTL -- requirements
Module: game_fsm_ctl

---
 rtl/game_fsm_ctl_if.sv | 10 +
 rtl/game_fsm_ctl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm_ctl_if.sv
// VGA raster position bundle shared by the timing generator and its consumers.
// The timing generator drives the master side; consumers read through slave or in.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;

    modport master (output hcount, output vcount);
    modport slave  (input  hcount, input  vcount);
    modport in     (input  hcount, input  vcount);
endinterface

// File: rtl/game_fsm_ctl.sv
// Battleship-style game controller: maps the mouse to board cells, runs placement/aim/resolve turns.
// Optional per-turn aim timeout is built only when GAME_CTL_TIMEOUT_EN is defined.
module game_fsm_ctl #(
    parameter int unsigned BOARD_N        = 10,
    parameter int unsigned CELL_PX        = 32,
    parameter int unsigned ORIGIN_X       = 608,
    parameter int unsigned ORIGIN_Y       = 193,
    parameter int unsigned SHIPS          = 10,
    parameter int unsigned HIT_TARGET     = 20,
    parameter int unsigned TIMEOUT_FRAMES = 600,
    localparam int unsigned CW = $clog2(BOARD_N),
    localparam int unsigned SW = $clog2(SHIPS + 1),
    localparam int unsigned HW = $clog2(HIT_TARGET + 1)
) (
    input  logic            clk,
    input  logic            rst,
    vga_if.in               vga_in,
    input  logic            mouse_left,
    input  logic [11:0]     mouse_xpos,
    input  logic [11:0]     mouse_ypos,
    input  logic            start_button,
    input  logic            first_player,
    input  logic [SW-1:0]   ship_count,
    input  logic            opp_done,
    input  logic            opp_win,
    input  logic            answer_valid,
    input  logic            answer_hit,
    output logic [2*CW-1:0] cell_pos,
    output logic            cell_valid,
    output logic            pick_ship,
    output logic            shot_req,
    output logic [2*CW-1:0] shot_pos,
    output logic [HW-1:0]   hit_count,
    output logic            game_over,
    output logic            win,
    output logic            turn_timeout,
    output logic [5:0]      state_led
);

    localparam int unsigned CELL_SH = $clog2(CELL_PX);
    localparam int unsigned X_END   = ORIGIN_X + BOARD_N * CELL_PX;
    localparam int unsigned Y_END   = ORIGIN_Y + BOARD_N * CELL_PX;

    // One-hot encoding so the state register doubles as the LED output.
    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        PLACE    = 6'b000010,
        WAIT_OPP = 6'b000100,
        AIM      = 6'b001000,
        RESOLVE  = 6'b010000,
        OVER     = 6'b100000
    } state_e;

    state_e          state_q, state_d;
    logic [2*CW-1:0] cell_pos_q;
    logic            cell_valid_q;
    logic            mouse_left_q;
    logic            pick_ship_q, pick_ship_d;
    logic            shot_req_q, shot_req_d;
    logic [2*CW-1:0] shot_pos_q, shot_pos_d;
    logic [HW-1:0]   hit_count_q, hit_count_d;
    logic            game_over_q, game_over_d;
    logic            win_q, win_d;
    logic            turn_timeout_q, turn_timeout_d;

    logic            fs_c;
    logic [11:0]     dx_c, dy_c;
    logic            in_board_c;
    logic [CW-1:0]   col_c, row_c;
    logic            click_c;
    logic            timeout_c;

    assign fs_c = (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);

    // Pixel-to-cell mapping; the range check guarantees the subtraction never wraps.
    assign dx_c       = mouse_xpos - 12'(ORIGIN_X);
    assign dy_c       = mouse_ypos - 12'(ORIGIN_Y);
    assign in_board_c = (mouse_xpos >= 12'(ORIGIN_X)) && (mouse_xpos < 12'(X_END)) &&
                        (mouse_ypos >= 12'(ORIGIN_Y)) && (mouse_ypos < 12'(Y_END));
    assign col_c      = CW'(dx_c >> CELL_SH);
    assign row_c      = CW'(dy_c >> CELL_SH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_pos_q   <= '0;
            cell_valid_q <= 1'b0;
        end else if (fs_c) begin
            cell_valid_q <= in_board_c;
            if (in_board_c) begin
                cell_pos_q <= {row_c, col_c};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mouse_left_q <= 1'b0;
        end else begin
            mouse_left_q <= mouse_left;
        end
    end

    assign click_c = mouse_left && !mouse_left_q && cell_valid_q;

`ifdef GAME_CTL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_FRAMES + 1);

    logic [TW-1:0] frame_cnt_q, frame_cnt_d;

    // Held at zero outside AIM, so every AIM entry starts a fresh count.
    always_comb begin
        frame_cnt_d = '0;
        if (state_q == AIM) begin
            frame_cnt_d = fs_c ? frame_cnt_q + TW'(1) : frame_cnt_q;
        end
    end

    assign timeout_c = (state_q == AIM) && fs_c && (frame_cnt_q == TW'(TIMEOUT_FRAMES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    // TIMEOUT_FRAMES is kept on the parameter list so both builds share one interface.
    assign timeout_c = 1'b0 & (TIMEOUT_FRAMES == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pick_ship_d    = 1'b0;
        shot_req_d     = 1'b0;
        shot_pos_d     = shot_pos_q;
        hit_count_d    = hit_count_q;
        win_d          = win_q;
        turn_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_button) begin
                    state_d = PLACE;
                end
            end
            PLACE: begin
                pick_ship_d = click_c;
                if (ship_count == SW'(SHIPS)) begin
                    state_d = first_player ? AIM : WAIT_OPP;
                end
            end
            WAIT_OPP: begin
                if (opp_win) begin
                    state_d = OVER;
                    win_d   = 1'b0;
                end else if (opp_done) begin
                    state_d = AIM;
                end
            end
            AIM: begin
                if (opp_win) begin
                    state_d = OVER;
                    win_d   = 1'b0;
                end else if (click_c) begin
                    shot_pos_d = cell_pos_q;
                    shot_req_d = 1'b1;
                    state_d    = RESOLVE;
                end else if (timeout_c) begin
                    turn_timeout_d = 1'b1;
                    state_d        = WAIT_OPP;
                end
            end
            RESOLVE: begin
                if (answer_valid) begin
                    if (answer_hit) begin
                        if (hit_count_q < HW'(HIT_TARGET)) begin
                            hit_count_d = hit_count_q + HW'(1);
                        end
                        if (hit_count_q >= HW'(HIT_TARGET - 1)) begin
                            state_d = OVER;
                            win_d   = 1'b1;
                        end else begin
                            state_d = AIM;
                        end
                    end else begin
                        state_d = WAIT_OPP;
                    end
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pick_ship_q    <= 1'b0;
            shot_req_q     <= 1'b0;
            shot_pos_q     <= '0;
            hit_count_q    <= '0;
            game_over_q    <= 1'b0;
            win_q          <= 1'b0;
            turn_timeout_q <= 1'b0;
        end else begin
            pick_ship_q    <= pick_ship_d;
            shot_req_q     <= shot_req_d;
            shot_pos_q     <= shot_pos_d;
            hit_count_q    <= hit_count_d;
            game_over_q    <= game_over_d;
            win_q          <= win_d;
            turn_timeout_q <= turn_timeout_d;
        end
    end

    assign cell_pos     = cell_pos_q;
    assign cell_valid   = cell_valid_q;
    assign pick_ship    = pick_ship_q;
    assign shot_req     = shot_req_q;
    assign shot_pos     = shot_pos_q;
    assign hit_count    = hit_count_q;
    assign game_over    = game_over_q;
    assign win          = win_q;
    assign turn_timeout = turn_timeout_q;
    assign state_led    = 6'(state_q);

endmodule
